// File: rtl/dac_spi_tx_if.sv
// Bundles the sample input and the serial-DAC side of the output stage.
// The filter side (master) drives the sample strobe and value; the
// output stage (slave) drives the SPI pins and the status flags.
interface dac_spi_tx_if;
  logic        rx;
  logic [24:0] u;
  logic        sclk;
  logic        sync_n;
  logic        sdata;
  logic        busy;
  logic        done;
  logic        ovf;

  modport master (
    output rx,
    output u,
    input  sclk,
    input  sync_n,
    input  sdata,
    input  busy,
    input  done,
    input  ovf
  );

  modport slave (
    input  rx,
    input  u,
    output sclk,
    output sync_n,
    output sdata,
    output busy,
    output done,
    output ovf
  );
endinterface

// File: rtl/dac_spi_tx.sv
// Output stage of the filter chain: saturates each 25-bit sample to a
// 12-bit offset-binary DAC code, parks it in a one-entry holding register
// and shifts it out MSB-first as a 16-bit SPI frame {CTRL, code}.
module dac_spi_tx #(
  parameter int         DAC_W = 12,
  parameter int         SHIFT = 10,
  parameter int         HALF  = 1,
  parameter logic [3:0] CTRL  = 4'b0011,
  parameter int         GAP   = 2
) (
  input  logic         clk,
  input  logic         rst,
  dac_spi_tx_if.slave  bus
);

  localparam int MSB = SHIFT + DAC_W - 1;
  localparam int HCW = (HALF > 1) ? $clog2(HALF) : 1;
  localparam int GCW = (GAP > 1) ? $clog2(GAP) : 1;
  localparam logic [HCW-1:0] HALF_LAST = HCW'(HALF - 1);
  localparam logic [GCW-1:0] GAP_LAST  = GCW'(GAP - 1);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_GAP} state_t;

  state_t           state;
  logic [DAC_W-1:0] c;
  logic [24-MSB:0]  top;
  logic             in_range;
  logic [DAC_W+3:0] word;
  logic [DAC_W+3:0] hold;
  logic             pend;
  logic             consume;
  logic [DAC_W+2:0] shreg;
  logic [HCW-1:0]   hcnt;
  logic [GCW-1:0]   gcnt;
  logic [3:0]       bit_cnt;
  logic             sclk_q;
  logic             sync_n_q;
  logic             sdata_q;
  logic             busy_q;
  logic             done_q;
  logic             ovf_q;
  logic             unused_low;

  // The discarded LSBs below the code window never influence the frame.
  assign unused_low = ^bus.u[SHIFT-1:0];

  // Saturate the sample into the code window and convert to a frame word.
  always_comb begin
    top      = bus.u[24:MSB];
    in_range = (&top) | ~(|top);
    if (in_range)
      c = bus.u[MSB:SHIFT];
    else if (bus.u[24])
      c = {1'b1, {(DAC_W-1){1'b0}}};
    else
      c = {1'b0, {(DAC_W-1){1'b1}}};
    word = {CTRL, ~c[DAC_W-1], c[DAC_W-2:0]};
  end

  // The FSM takes the pending sample only while idle.
  assign consume = (state == S_IDLE) && pend;

  // Holding register: a new sample always wins; losing an unsent one is flagged.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold  <= '0;
      pend  <= 1'b0;
      ovf_q <= 1'b0;
    end else if (bus.rx) begin
      hold <= word;
      pend <= 1'b1;
      if (pend && !consume)
        ovf_q <= 1'b1;
    end else if (consume) begin
      pend <= 1'b0;
    end
  end

  // Frame sequencer: idle, shift 16 bits on sclk, then hold sync_n high for GAP clocks.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      shreg    <= '0;
      hcnt     <= '0;
      gcnt     <= '0;
      bit_cnt  <= '0;
      sclk_q   <= 1'b0;
      sync_n_q <= 1'b1;
      sdata_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (pend) begin
            shreg    <= hold[DAC_W+2:0];
            sdata_q  <= hold[DAC_W+3];
            sync_n_q <= 1'b0;
            sclk_q   <= 1'b0;
            busy_q   <= 1'b1;
            hcnt     <= '0;
            bit_cnt  <= '0;
            state    <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          if (hcnt == HALF_LAST) begin
            hcnt <= '0;
            if (!sclk_q) begin
              sclk_q <= 1'b1;
            end else begin
              sclk_q <= 1'b0;
              if (bit_cnt == 4'd15) begin
                sync_n_q <= 1'b1;
                sdata_q  <= 1'b0;
                gcnt     <= '0;
                state    <= S_GAP;
              end else begin
                sdata_q <= shreg[DAC_W+2];
                shreg   <= {shreg[DAC_W+1:0], 1'b0};
                bit_cnt <= bit_cnt + 4'd1;
              end
            end
          end else begin
            hcnt <= hcnt + 1'b1;
          end
        end
        S_GAP: begin
          if (gcnt == GAP_LAST) begin
            busy_q <= 1'b0;
            done_q <= 1'b1;
            state  <= S_IDLE;
          end else begin
            gcnt <= gcnt + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.sclk   = sclk_q;
  assign bus.sync_n = sync_n_q;
  assign bus.sdata  = sdata_q;
  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.ovf    = ovf_q;

endmodule
